// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit CPU control path:
// opcodes, T-states and control-word bit positions.
package cpu_ctrl_pkg;

  localparam int STEPS    = 5;
  localparam int OPCODE_W = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam int CW_PC_EN   = 0;
  localparam int CW_PC_OE   = 1;
  localparam int CW_PC_LD   = 2;
  localparam int CW_MAR_LD  = 3;
  localparam int CW_RAM_OE  = 4;
  localparam int CW_RAM_WE  = 5;
  localparam int CW_IR_LD   = 6;
  localparam int CW_IR_OE   = 7;
  localparam int CW_A_LD    = 8;
  localparam int CW_A_OE    = 9;
  localparam int CW_B_LD    = 10;
  localparam int CW_ALU_OE  = 11;
  localparam int CW_ALU_SUB = 12;
  localparam int CW_FL_LD   = 13;
  localparam int CW_OUT_LD  = 14;
  localparam int CW_W       = 15;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// T-state counter: wraps at STEPS-1, holds while
// freeze is high, async active-high reset.
module step_counter #(
  parameter int STEPS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  output logic [2:0] step
);

  localparam logic [2:0] LAST = 3'(STEPS - 1);

  logic [2:0] step_q;
  logic [2:0] step_d;

  always_comb begin
    step_d = step_q;
    if (!freeze) begin
      step_d = (step_q == LAST) ? 3'd0 : step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= '0;
    else     step_q <= step_d;
  end

  assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: decodes (step, opcode, flags)
// into datapath strobes and owns the halt latch.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int STEPS    = 5,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic                pc_en,
  output logic                pc_oe,
  output logic                pc_ld,
  output logic                mar_ld,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                ir_ld,
  output logic                ir_oe,
  output logic                a_ld,
  output logic                a_oe,
  output logic                b_ld,
  output logic                alu_oe,
  output logic                alu_sub,
  output logic                fl_ld,
  output logic                out_ld,
  output logic                halted,
  output logic [2:0]          step
);

  logic [2:0]      step_q;
  logic            halted_q;
  logic            halted_d;
  logic [CW_W-1:0] cw;
  logic [CW_W-1:0] ctrl;

  step_counter #(
    .STEPS (STEPS)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .freeze (halted_q),
    .step   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  // Halt takes effect on the edge that ends T2 of HLT.
  always_comb begin
    halted_d = halted_q;
    if (step_q == T2 && opcode == OP_HLT) begin
      halted_d = 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    unique case (step_q)
      T0: begin
        cw[CW_PC_OE]  = 1'b1;
        cw[CW_MAR_LD] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_OE] = 1'b1;
        cw[CW_IR_LD]  = 1'b1;
        cw[CW_PC_EN]  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OE]  = 1'b1;
            cw[CW_MAR_LD] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OE] = 1'b1;
            cw[CW_A_LD]  = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OE] = 1'b1;
            cw[CW_PC_LD] = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OE] = flag_c;
            cw[CW_PC_LD] = flag_c;
          end
          OP_JZ: begin
            cw[CW_IR_OE] = flag_z;
            cw[CW_PC_LD] = flag_z;
          end
          OP_OUT: begin
            cw[CW_A_OE]   = 1'b1;
            cw[CW_OUT_LD] = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OE] = 1'b1;
            cw[CW_A_LD]   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OE] = 1'b1;
            cw[CW_B_LD]   = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OE]   = 1'b1;
            cw[CW_RAM_WE] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_OE]  = 1'b1;
          cw[CW_A_LD]    = 1'b1;
          cw[CW_FL_LD]   = 1'b1;
          cw[CW_ALU_SUB] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // rst gates strobes so an abort drops them immediately.
  assign ctrl = (rst || halted_q) ? '0 : cw;

  assign pc_en   = ctrl[CW_PC_EN];
  assign pc_oe   = ctrl[CW_PC_OE];
  assign pc_ld   = ctrl[CW_PC_LD];
  assign mar_ld  = ctrl[CW_MAR_LD];
  assign ram_oe  = ctrl[CW_RAM_OE];
  assign ram_we  = ctrl[CW_RAM_WE];
  assign ir_ld   = ctrl[CW_IR_LD];
  assign ir_oe   = ctrl[CW_IR_OE];
  assign a_ld    = ctrl[CW_A_LD];
  assign a_oe    = ctrl[CW_A_OE];
  assign b_ld    = ctrl[CW_B_LD];
  assign alu_oe  = ctrl[CW_ALU_OE];
  assign alu_sub = ctrl[CW_ALU_SUB];
  assign fl_ld   = ctrl[CW_FL_LD];
  assign out_ld  = ctrl[CW_OUT_LD];
  assign halted  = halted_q;
  assign step    = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle
// vector table plus halt, abort and bus sequences.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       flag_c, flag_z;
  logic pc_en, pc_oe, pc_ld, mar_ld, ram_oe, ram_we;
  logic ir_ld, ir_oe, a_ld, a_oe, b_ld, alu_oe;
  logic alu_sub, fl_ld, out_ld, halted;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] PC_EN   = 15'h0001;
  localparam logic [14:0] PC_OE   = 15'h0002;
  localparam logic [14:0] PC_LD   = 15'h0004;
  localparam logic [14:0] MAR_LD  = 15'h0008;
  localparam logic [14:0] RAM_OE  = 15'h0010;
  localparam logic [14:0] RAM_WE  = 15'h0020;
  localparam logic [14:0] IR_LD   = 15'h0040;
  localparam logic [14:0] IR_OE   = 15'h0080;
  localparam logic [14:0] A_LD    = 15'h0100;
  localparam logic [14:0] A_OE    = 15'h0200;
  localparam logic [14:0] B_LD    = 15'h0400;
  localparam logic [14:0] ALU_OE  = 15'h0800;
  localparam logic [14:0] ALU_SUB = 15'h1000;
  localparam logic [14:0] FL_LD   = 15'h2000;
  localparam logic [14:0] OUT_LD  = 15'h4000;
  localparam logic [14:0] NONE    = 15'h0000;
  localparam logic [14:0] FETCH0  = PC_OE | MAR_LD;
  localparam logic [14:0] FETCH1  = RAM_OE | IR_LD | PC_EN;

  typedef struct {
    logic [3:0]  op;
    logic        fc;
    logic        fz;
    logic [2:0]  st;
    logic [14:0] cw;
  } vec_t;

  vec_t vecs[80];
  int   nvec = 0;

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_en(pc_en), .pc_oe(pc_oe), .pc_ld(pc_ld),
    .mar_ld(mar_ld), .ram_oe(ram_oe), .ram_we(ram_we),
    .ir_ld(ir_ld), .ir_oe(ir_oe), .a_ld(a_ld),
    .a_oe(a_oe), .b_ld(b_ld), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .fl_ld(fl_ld), .out_ld(out_ld),
    .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] cw_now();
    logic [14:0] v;
    v = NONE;
    if (pc_en)   v |= PC_EN;
    if (pc_oe)   v |= PC_OE;
    if (pc_ld)   v |= PC_LD;
    if (mar_ld)  v |= MAR_LD;
    if (ram_oe)  v |= RAM_OE;
    if (ram_we)  v |= RAM_WE;
    if (ir_ld)   v |= IR_LD;
    if (ir_oe)   v |= IR_OE;
    if (a_ld)    v |= A_LD;
    if (a_oe)    v |= A_OE;
    if (b_ld)    v |= B_LD;
    if (alu_oe)  v |= ALU_OE;
    if (alu_sub) v |= ALU_SUB;
    if (fl_ld)   v |= FL_LD;
    if (out_ld)  v |= OUT_LD;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic add_instr(input logic [3:0] op, input logic fc,
                           input logic fz, input logic [14:0] e2,
                           input logic [14:0] e3, input logic [14:0] e4);
    logic [14:0] e[5];
    e[0] = FETCH0; e[1] = FETCH1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int s = 0; s < 5; s++) begin
      vecs[nvec].op = op;
      vecs[nvec].fc = fc;
      vecs[nvec].fz = fz;
      vecs[nvec].st = 3'(s);
      vecs[nvec].cw = e[s];
      nvec++;
    end
  endtask

  // Reset held over two edges; releases at a negedge so
  // the cycle in progress is T0.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; opcode = 4'hf; flag_c = 1'b1; flag_z = 1'b1;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_cw", 32'(cw_now()), 32'(NONE));
    chk("reset_halted", 32'(halted), 32'd0);
    @(negedge clk);
    #1;
    chk("reset_hold_cw", 32'(cw_now()), 32'(NONE));

    add_instr(4'h0, 0, 0, NONE, NONE, NONE);
    add_instr(4'h1, 0, 0, IR_OE | MAR_LD, RAM_OE | A_LD, NONE);
    add_instr(4'h2, 0, 0, IR_OE | MAR_LD, RAM_OE | B_LD,
              ALU_OE | A_LD | FL_LD);
    add_instr(4'h3, 0, 0, IR_OE | MAR_LD, RAM_OE | B_LD,
              ALU_OE | A_LD | FL_LD | ALU_SUB);
    add_instr(4'h4, 0, 0, IR_OE | MAR_LD, A_OE | RAM_WE, NONE);
    add_instr(4'h5, 0, 0, IR_OE | A_LD, NONE, NONE);
    add_instr(4'h6, 0, 0, IR_OE | PC_LD, NONE, NONE);
    add_instr(4'h7, 0, 1, NONE, NONE, NONE);
    add_instr(4'h7, 1, 0, IR_OE | PC_LD, NONE, NONE);
    add_instr(4'h8, 1, 0, NONE, NONE, NONE);
    add_instr(4'h8, 0, 1, IR_OE | PC_LD, NONE, NONE);
    add_instr(4'he, 1, 1, A_OE | OUT_LD, NONE, NONE);
    add_instr(4'h9, 1, 1, NONE, NONE, NONE);
    add_instr(4'hd, 1, 1, NONE, NONE, NONE);

    opcode = vecs[0].op;
    rst = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      opcode = vecs[i].op;
      flag_c = vecs[i].fc;
      flag_z = vecs[i].fz;
      #1;
      chk($sformatf("vec%0d_op%h_step", i, vecs[i].op),
          32'(step), 32'(vecs[i].st));
      chk($sformatf("vec%0d_op%h_T%0d_cw", i, vecs[i].op, vecs[i].st),
          32'(cw_now()), 32'(vecs[i].cw));
      @(negedge clk);
    end

    // Fetch period: NOP stream, pc_en once per instruction.
    opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("nop_step%0d", i), 32'(step), 32'(i % 5));
      if (pc_en) pulses++;
      @(negedge clk);
    end
    chk("nop_pc_en_pulses", 32'(pulses), 32'd4);

    // Halt: frozen at T3 with no strobes.
    opcode = 4'hf;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hlt_pre_halted%0d", i), 32'(halted), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i);
      #1;
      chk($sformatf("hlt_halted%0d", i), 32'(halted), 32'd1);
      chk($sformatf("hlt_step%0d", i), 32'(step), 32'd3);
      chk($sformatf("hlt_cw%0d", i), 32'(cw_now()), 32'(NONE));
      @(negedge clk);
    end
    do_reset();
    #1;
    chk("hlt_cleared", 32'(halted), 32'd0);
    chk("hlt_resume_cw", 32'(cw_now()), 32'(FETCH0));

    // Abort in T3 of LDA.
    opcode = 4'h1;
    do_reset();
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk("abort_pre_step", 32'(step), 32'd3);
    chk("abort_pre_cw", 32'(cw_now()), 32'(RAM_OE | A_LD));
    #1 rst = 1'b1;
    #1;
    chk("abort_cw", 32'(cw_now()), 32'(NONE));
    chk("abort_step", 32'(step), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_hold_cw", 32'(cw_now()), 32'(NONE));
    rst = 1'b0;
    #1;
    chk("abort_resume_cw", 32'(cw_now()), 32'(FETCH0));
    @(negedge clk);
    #1;
    chk("abort_resume_t1", 32'(cw_now()), 32'(FETCH1));
    @(negedge clk);

    // Random bus-contention sweep with short resets.
    for (int i = 0; i < 500; i++) begin
      opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) == 0);
      #1;
      chk($sformatf("bus_oe%0d", i),
          32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1),
          32'd1);
      @(negedge clk);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit CPU. Generates every datapath control strobe: program counter, MAR, RAM, IR, A/B registers, ALU, flags and output register.
- Runs a fixed five-step (T0..T4) machine per instruction: fetch in T0-T1, execute in T2-T4, decoded from the IR opcode nibble and the flags register.
- Owns halt: once HLT executes, the CPU freezes until reset.

Parameters:
- STEPS, 5, T-states per instruction; the step counter wraps from STEPS-1 to 0.
- OPCODE_W, 4, opcode width (upper nibble of IR).

Ports:
- clk  in  1  system clock; all state advances on the rising edge.
- rst  in  1  asynchronous active-high reset.
- opcode  in  4  IR[7:4]; valid from T2.
- flag_c  in  1  registered carry flag.
- flag_z  in  1  registered zero flag.
- pc_en  out  1  increment PC.
- pc_oe  out  1  PC drives bus.
- pc_ld  out  1  load PC from bus.
- mar_ld  out  1  load MAR.
- ram_oe  out  1  RAM drives bus.
- ram_we  out  1  write RAM from bus.
- ir_ld  out  1  load IR.
- ir_oe  out  1  IR[3:0] drives bus.
- a_ld  out  1  load A.
- a_oe  out  1  A drives bus.
- b_ld  out  1  load B.
- alu_oe  out  1  ALU drives bus.
- alu_sub  out  1  ALU subtract.
- fl_ld  out  1  load flags.
- out_ld  out  1  load output register.
- halted  out  1  CPU halted.
- step  out  3  current T-state, for debug.

Behaviour:
- Reset (async): step=0, halted=0. While rst=1, all control outputs are 0. The first cycle after release is T0.
- Step counter: 3-bit, increments every rising edge; T4 wraps to T0. Every instruction takes exactly 5 cycles, with no early termination.
- Control outputs are combinational from (step, opcode, flags, halted). The datapath samples them on the same rising edge that advances step.
- Fetch (every instruction):
  - T0: pc_oe, mar_ld.
  - T1: ram_oe, ir_ld, pc_en.
- Execute (T2/T3/T4; unlisted steps have no strobes):
  - NOP 0000: none.
  - LDA 0001: T2 ir_oe+mar_ld; T3 ram_oe+a_ld.
  - ADD 0010: T2 ir_oe+mar_ld; T3 ram_oe+b_ld; T4 alu_oe+a_ld+fl_ld.
  - SUB 0011: same as ADD, plus alu_sub=1 in T4 only.
  - STA 0100: T2 ir_oe+mar_ld; T3 a_oe+ram_we.
  - LDI 0101: T2 ir_oe+a_ld.
  - JMP 0110: T2 ir_oe+pc_ld.
  - JC 0111: T2 ir_oe+pc_ld only if flag_c=1, else none.
  - JZ 1000: T2 ir_oe+pc_ld only if flag_z=1, else none.
  - OUT 1110: T2 a_oe+out_ld.
  - HLT 1111: none; halted is set on the rising edge ending T2.
  - All other opcodes: treated as NOP.
- Flag sampling: flag_c and flag_z are sampled combinationally during T2, so a flag loaded in a prior instruction's T4 is visible.
- Halted: step freezes at 3, all control outputs are 0, halted=1. Only rst clears it.
- Bus invariant: at most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle.
- Reset mid-instruction: aborts immediately; no partial strobes after rst rises.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - T-state constants T0..T4;
  - control-word bit indices, so the datapath top can bundle strobes.
- One sub-module, step_counter: 3-bit wrap-at-STEPS counter with async reset and freeze input (driven by halted).
- Decode stays in control_sequencer as a case on step/opcode.

Test Plan:
- Reset: hold rst=1 across edges -> step=0, all strobes 0, halted=0. Release -> next cycle step=0 with pc_oe=1, mar_ld=1; following cycle ram_oe=1, ir_ld=1, pc_en=1.
- Fetch period: opcode=0000 for 20 cycles -> pc_en pulses exactly every 5th cycle (4 pulses); step sequence 0,1,2,3,4,0.
- ADD/SUB:
  - opcode=0010 -> T2 ir_oe+mar_ld, T3 ram_oe+b_ld, T4 alu_oe+a_ld+fl_ld with alu_sub=0.
  - opcode=0011 -> identical except alu_sub=1 at T4.
- Conditional jump: opcode=1000 with flag_z=0 -> T2 no pc_ld and no ir_oe. Repeat with flag_z=1 -> T2 ir_oe=1, pc_ld=1. Same check for JC with flag_c.
- Halt and reset mid-op:
  - opcode=1111 -> halted=1 from the cycle after T2; step stays 3 and all strobes are 0 for 20 cycles.
  - Assert rst mid-T3 of an LDA -> outputs drop to 0 asynchronously; resume at T0 after release.
- Bus invariant: 500 cycles of random opcode/flags with random short resets -> never more than one *_oe high in the same cycle.
